// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch sequencer.
// MISALIGN_TRAP_EN adds the TRAP state used for misaligned redirect targets.
package riscv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_BOOT,
    ST_ISSUE,
    ST_WAIT,
    ST_DROP,
    ST_TRAP
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_ISSUE,
    ST_WAIT,
    ST_DROP
  } fetch_state_t;
`endif

  typedef enum logic [1:0] {
    PC_SEL_HOLD,
    PC_SEL_STEP,
    PC_SEL_REDIRECT
  } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: hold, sequential step, or redirect target.
// Contains the single PC adder; wraps modulo 2^32.
module pc_next_mux
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] STEP = riscv_fetch_pkg::PC_STEP
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_redirect_target,
  input  pc_sel_t         i_sel,
  output logic [XLEN-1:0] o_pc_next
);

  logic [XLEN-1:0] w_pc_step;

  assign w_pc_step = i_pc + STEP;

  always_comb begin
    o_pc_next = i_pc;
    case (i_sel)
      PC_SEL_STEP:     o_pc_next = w_pc_step;
      PC_SEL_REDIRECT: o_pc_next = i_redirect_target;
      default:         o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer with a one-entry decode buffer.
// Optional MISALIGN_TRAP_EN: misaligned redirects trap instead of being force-aligned.
module pc_fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = riscv_fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = riscv_fetch_pkg::PC_STEP
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_stall,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_inst,
`ifdef MISALIGN_TRAP_EN
  output logic            o_misalign,
`endif
  input  logic            i_if_ready
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_target;
  pc_sel_t         w_pc_sel;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_inst;
  logic            w_redirect;
  logic            w_slot_free;
  logic            w_req;
  logic            w_load;
  logic            w_misalign_next;

`ifdef MISALIGN_TRAP_EN
  logic            r_misalign;
  assign w_target = i_redirect_target;
`else
  assign w_target = i_redirect_target & ~32'h3;
`endif

  assign w_redirect  = i_redirect_valid && (r_state != ST_BOOT);
  assign w_slot_free = !r_if_valid || i_if_ready;

  always_comb begin
    w_state_next    = r_state;
    w_pc_sel        = PC_SEL_HOLD;
    w_req           = 1'b0;
    w_load          = 1'b0;
    w_misalign_next = 1'b0;
    case (r_state)
      ST_BOOT: w_state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (w_redirect) begin
          w_pc_sel = PC_SEL_REDIRECT;
        end else if (w_slot_free && !i_stall) begin
          w_req        = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect racing the ack discards the data; otherwise the ack is still owed.
        if (w_redirect) begin
          w_pc_sel     = PC_SEL_REDIRECT;
          w_state_next = i_imem_ack ? ST_ISSUE : ST_DROP;
        end else if (i_imem_ack) begin
          w_load       = 1'b1;
          w_pc_sel     = PC_SEL_STEP;
          w_state_next = ST_ISSUE;
        end
      end
      ST_DROP: begin
        if (w_redirect) begin
          w_pc_sel = PC_SEL_REDIRECT;
        end
        if (i_imem_ack) begin
          w_state_next = ST_ISSUE;
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_TRAP: begin
        if (w_redirect) begin
          w_pc_sel     = PC_SEL_REDIRECT;
          w_state_next = ST_ISSUE;
        end
      end
`endif
      default: w_state_next = ST_BOOT;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (w_redirect && (w_target[1:0] != 2'b00)) begin
      w_misalign_next = 1'b1;
      w_state_next    = ST_TRAP;
    end
`endif
  end

  pc_next_mux #(
    .STEP(PC_STEP)
  ) u_pc_next_mux (
    .i_pc             (r_pc),
    .i_redirect_target(w_target),
    .i_sel            (w_pc_sel),
    .o_pc_next        (w_pc_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_redirect) begin
        r_if_valid <= 1'b0;
      end else if (w_load) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_pc;
        r_if_inst  <= i_imem_rdata;
      end else if (r_if_valid && i_if_ready) begin
        r_if_valid <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_next;
    end
  end
  assign o_misalign = r_misalign;
`else
  // Keeps the default build free of a dangling combinational term.
  logic w_unused_misalign;
  assign w_unused_misalign = w_misalign_next;
`endif

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_inst   = r_if_inst;

endmodule
